// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like slave between the IF fetch port and the MEM data port, routing in-order responses via an ID FIFO.
// Optional macro ARB_ROUND_ROBIN_EN switches unlocked arbitration from fixed data-first to round-robin.
module sram_bus_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rsp_rdata,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    LOCK_NONE,
    LOCK_INST,
    LOCK_DATA
  } lock_t;

  lock_t            r_lock;
  logic [DEPTH-1:0] r_fifoIds;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;
`ifdef ARB_ROUND_ROBIN_EN
  logic             r_rrData;
`endif

  logic w_grantData;
  logic w_full;
  logic w_sramReq;
  logic w_push;
  logic w_pop;
  logic w_headData;

  // A pending lock pins the grant so the slave never sees the request change under it.
  always_comb begin
    w_grantData = data_req;
    if (r_lock == LOCK_DATA) begin
      w_grantData = 1'b1;
    end else if (r_lock == LOCK_INST) begin
      w_grantData = 1'b0;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (data_req && inst_req) begin
        w_grantData = r_rrData;
      end
`endif
    end
  end

  assign w_full     = (r_count == (PW+1)'(DEPTH));
  assign w_sramReq  = ~rst & (inst_req | data_req) & ~w_full;
  assign w_push     = w_sramReq & sram_addr_ok;
  assign w_pop      = ~rst & sram_data_ok & (r_count != '0);
  assign w_headData = r_fifoIds[r_head];

  assign sram_req     = w_sramReq;
  assign sram_wr      = w_sramReq & w_grantData & (|data_wstrb);
  assign sram_size    = !w_sramReq ? 2'b00 : (w_grantData ? data_size : 2'b10);
  assign sram_wstrb   = (w_sramReq && w_grantData) ? data_wstrb : 4'b0000;
  assign sram_addr    = !w_sramReq ? 32'h0 : (w_grantData ? data_addr : inst_addr);
  assign sram_wdata   = (w_sramReq && w_grantData) ? data_wdata : 32'h0;

  assign inst_addr_ok = w_push & ~w_grantData;
  assign data_addr_ok = w_push & w_grantData;
  assign inst_data_ok = w_pop & ~w_headData;
  assign data_data_ok = w_pop & w_headData;
  assign rsp_rdata    = sram_rdata;

  // Lock tracking, in-order ID FIFO and (optionally) the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock    <= LOCK_NONE;
      r_fifoIds <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rrData  <= 1'b1;
`endif
    end else begin
      if (w_sramReq && !sram_addr_ok) begin
        r_lock <= w_grantData ? LOCK_DATA : LOCK_INST;
      end else if (w_push) begin
        r_lock <= LOCK_NONE;
      end

      if (w_push) begin
        r_fifoIds[r_tail] <= w_grantData;
        r_tail            <= r_tail + PW'(1);
`ifdef ARB_ROUND_ROBIN_EN
        r_rrData          <= ~w_grantData;
`endif
      end

      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: expected response ids are queued on accepted addresses and checked on data_ok.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instReq;
  logic [31:0] instAddr;
  logic        instAddrOk, instDataOk;
  logic        dataReq;
  logic [1:0]  dataSize;
  logic [3:0]  dataWstrb;
  logic [31:0] dataAddr, dataWdata;
  logic        dataAddrOk, dataDataOk;
  logic [31:0] rspRdata;
  logic        sramReq, sramWr;
  logic [1:0]  sramSize;
  logic [3:0]  sramWstrb;
  logic [31:0] sramAddr, sramWdata;
  logic        sramAddrOk, sramDataOk;
  logic [31:0] sramRdata;

  int cmpCount = 0;
  int errCount = 0;
  bit expIds[$];

  always #5 clk = ~clk;

  sram_bus_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(instReq), .inst_addr(instAddr),
    .inst_addr_ok(instAddrOk), .inst_data_ok(instDataOk),
    .data_req(dataReq), .data_size(dataSize), .data_wstrb(dataWstrb),
    .data_addr(dataAddr), .data_wdata(dataWdata),
    .data_addr_ok(dataAddrOk), .data_data_ok(dataDataOk),
    .rsp_rdata(rspRdata),
    .sram_req(sramReq), .sram_wr(sramWr), .sram_size(sramSize),
    .sram_wstrb(sramWstrb), .sram_addr(sramAddr), .sram_wdata(sramWdata),
    .sram_addr_ok(sramAddrOk), .sram_data_ok(sramDataOk), .sram_rdata(sramRdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic [31:0] dAddr,
                               input logic aOk, input logic dOk, input logic [31:0] rdata);
    instReq    = iReq;
    instAddr   = iAddr;
    dataReq    = dReq;
    dataAddr   = dAddr;
    sramAddrOk = aOk;
    sramDataOk = dOk;
    sramRdata  = rdata;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expect an address handshake for the given port and queue its id.
  task automatic checkAccept(input string tag, input bit isData);
    checkOutput({tag, "_inst_addr_ok"}, 32'(instAddrOk), 32'(!isData));
    checkOutput({tag, "_data_addr_ok"}, 32'(dataAddrOk), 32'(isData));
    expIds.push_back(isData);
  endtask

  // Expect the response under way to be routed to the oldest queued id.
  task automatic checkResp(input string tag);
    bit id;
    if (expIds.size() == 0) begin
      cmpCount++;
      errCount++;
      $error("[TB] FAIL %s observed=response expected=empty_scoreboard", tag);
    end else begin
      id = expIds.pop_front();
      checkOutput({tag, "_inst_data_ok"}, 32'(instDataOk), 32'(!id));
      checkOutput({tag, "_data_data_ok"}, 32'(dataDataOk), 32'(id));
      checkOutput({tag, "_rdata"}, rspRdata, sramRdata);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_sram_req"}, 32'(sramReq), 32'h0);
    checkOutput({tag, "_addr_oks"}, 32'({instAddrOk, dataAddrOk}), 32'h0);
    checkOutput({tag, "_data_oks"}, 32'({instDataOk, dataDataOk}), 32'h0);
    checkOutput({tag, "_sram_addr"}, sramAddr, 32'h0);
    checkOutput({tag, "_sram_fields"}, 32'({sramWr, sramSize, sramWstrb}), 32'h0);
    checkOutput({tag, "_sram_wdata"}, sramWdata, 32'h0);
  endtask

  task automatic drain(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 32'hD000_0000 + 32'(k));
      checkResp(tag);
      tick();
    end
    sramDataOk = 0;
    sramRdata  = 0;
  endtask

  task automatic doReset();
    rst = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 0;
    expIds.delete();
  endtask

  // Linear directed sequence covering arbitration, lock, full, store, reset and protocol-error cases.
  initial begin
    rst = 1;
    dataSize = 2'b10; dataWstrb = 4'b0000; dataWdata = 32'h0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkIdleOutputs("reset");
    tick();
    rst = 0;

    // Both request together: data first, then inst, responses in issue order.
    applyStimulus(1, 32'h1c00_0000, 1, 32'h0000_1000, 1, 0, 0);
    checkAccept("t1c0", 1);
    checkOutput("t1c0_addr", sramAddr, 32'h0000_1000);
    checkOutput("t1c0_wr", 32'(sramWr), 32'h0);
    tick();
    applyStimulus(1, 32'h1c00_0000, 0, 0, 1, 0, 0);
    checkAccept("t1c1", 0);
    checkOutput("t1c1_addr", sramAddr, 32'h1c00_0000);
    checkOutput("t1c1_size", 32'(sramSize), 32'h2);
    tick();
    drain("t1resp", 2);

    // Stalled fetch holds the grant even after data asks.
    applyStimulus(1, 32'h1c00_0000, 0, 0, 0, 0, 0);
    checkOutput("t2c0_addr", sramAddr, 32'h1c00_0000);
    tick();
    applyStimulus(1, 32'h1c00_0000, 1, 32'h0000_2000, 0, 0, 0);
    checkOutput("t2c1_addr", sramAddr, 32'h1c00_0000);
    checkOutput("t2c1_data_addr_ok", 32'(dataAddrOk), 32'h0);
    tick();
    applyStimulus(1, 32'h1c00_0000, 1, 32'h0000_2000, 0, 0, 0);
    checkOutput("t2c2_addr", sramAddr, 32'h1c00_0000);
    tick();
    applyStimulus(1, 32'h1c00_0000, 1, 32'h0000_2000, 1, 0, 0);
    checkAccept("t2c3", 0);
    tick();
    applyStimulus(0, 0, 1, 32'h0000_2000, 1, 0, 0);
    checkAccept("t2c4", 1);
    checkOutput("t2c4_addr", sramAddr, 32'h0000_2000);
    tick();
    drain("t2resp", 2);

    // Fill the ID FIFO, then exercise the stall and simultaneous push+pop.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h1c00_0000 + 32'(4*k), 0, 0, 1, 0, 0);
      checkAccept("t3fill", 0);
      tick();
    end
    applyStimulus(1, 32'h1c00_0010, 0, 0, 1, 0, 0);
    checkOutput("t3full_req", 32'(sramReq), 32'h0);
    checkOutput("t3full_addr_ok", 32'(instAddrOk), 32'h0);
    tick();
    applyStimulus(1, 32'h1c00_0010, 0, 0, 1, 1, 32'h3333_0000);
    checkOutput("t3popfull_req", 32'(sramReq), 32'h0);
    checkResp("t3popfull");
    tick();
    applyStimulus(1, 32'h1c00_0010, 0, 0, 1, 1, 32'h3333_0001);
    checkOutput("t3both_req", 32'(sramReq), 32'h1);
    checkResp("t3both");
    checkAccept("t3both", 0);
    tick();
    applyStimulus(1, 32'h1c00_0014, 0, 0, 1, 0, 0);
    checkOutput("t3refill_req", 32'(sramReq), 32'h1);
    checkAccept("t3refill", 0);
    tick();
    applyStimulus(1, 32'h1c00_0018, 0, 0, 1, 0, 0);
    checkOutput("t3refull_req", 32'(sramReq), 32'h0);
    tick();
    drain("t3resp", 4);

    // Halfword store passes straight through.
    dataSize = 2'b01; dataWstrb = 4'b0011; dataWdata = 32'hABCD_ABCD;
    applyStimulus(0, 0, 1, 32'h0000_1002, 1, 0, 0);
    checkAccept("t4", 1);
    checkOutput("t4_wr", 32'(sramWr), 32'h1);
    checkOutput("t4_size", 32'(sramSize), 32'h1);
    checkOutput("t4_wstrb", 32'(sramWstrb), 32'h3);
    checkOutput("t4_addr", sramAddr, 32'h0000_1002);
    checkOutput("t4_wdata", sramWdata, 32'hABCD_ABCD);
    tick();
    dataSize = 2'b10; dataWstrb = 4'b0000; dataWdata = 32'h0;
    drain("t4resp", 1);

    // Reset with two outstanding, then a stray data_ok must be ignored.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 32'h1c00_0100, 0, 0, 1, 0, 0);
      checkAccept("t5fill", 0);
      tick();
    end
    rst = 1;
    applyStimulus(1, 32'h1c00_0100, 0, 0, 1, 0, 0);
    checkIdleOutputs("t5rst");
    tick();
    rst = 0;
    expIds.delete();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h5555_5555);
    checkOutput("t5stray_data_oks", 32'({instDataOk, dataDataOk}), 32'h0);
    tick();
    applyStimulus(0, 0, 1, 32'h0000_3000, 1, 0, 0);
    checkAccept("t5after", 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h6666_6666);
    checkResp("t5after_resp");
    checkOutput("t5after_empty_req", 32'(sramReq), 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h7777_7777);
    checkOutput("t5under_data_oks", 32'({instDataOk, dataDataOk}), 32'h0);
    tick();

    // Both requesting continuously from a fresh reset.
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h1c00_0200, 1, 32'h0000_4000, 1, 0, 0);
`ifdef ARB_ROUND_ROBIN_EN
      checkAccept("t6", (k % 2) == 0);
`else
      checkAccept("t6", 1'b1);
`endif
      tick();
    end
    drain("t6resp", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
